bsg_hash_bank_reverse_pipe: RTL and testbench
=============================================

Name: bsg_hash_bank_reverse_pipe

Overview:
Parametrised, pipelined successor to the single-bank combinational reverse hash. It takes a bank-local index plus a bank id and rebuilds the global address. Banks are interleaved in either low-order or high-order mode, and bank counts need not be powers of two. It sits on the return path of banked memory/network tiles, behind a valid/ready handshake, and flags and counts bank ids that are out of range.

Parameters:
width_p, 16, width of bank-local index_i
banks_p, 4, number of banks, >=1, any integer (not restricted to power of two)
mode_p, 0, 0 = low-order interleave (addr = index*banks_p + bank); 1 = high-order (addr = bank*2^width_p + index)
lg_banks_lp, derived, $clog2(banks_p) (0 when banks_p=1)
bank_width_lp, derived, max(1, lg_banks_lp)
o_width_lp, derived, width_p + lg_banks_lp

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  reset, synchronous, active-high
v_i  input  1  input valid
ready_o  output  1  input ready; transfer when v_i & ready_o
index_i  input  width_p  bank-local index
bank_i  input  bank_width_lp  bank id
v_o  output  1  output valid
o  output  o_width_lp  reconstructed global address
err_o  output  1  output entry had bank_i >= banks_p
yumi_i  input  1  consumer accepts output; legal only when v_o=1
err_count_o  output  8  saturating count of erroneous entries consumed

Behaviour:
- Structure: two registered stages. S1 captures index_i, bank_i and the range-check result. S2 holds the computed address and the err bit. Each stage has a valid bit.
- Reset (sync, while reset_i=1): S1/S2 valid cleared, so v_o=0. o=0, err_o=0, err_count_o=0. ready_o=0 during reset and 1 in the first cycle after.
- Reset mid-operation: all in-flight entries are discarded, never emitted, and not counted.
- Handshakes:
  - S2 can load when !v_s2 | yumi_i.
  - S1 advances when v_s1 & S2-can-load.
  - ready_o = !v_s1 | S1-advances. This is combinational from yumi_i, which is permitted.
- Throughput and latency: one entry per cycle when yumi_i is held high. An entry accepted at cycle N is presented on v_o/o at N+2 earliest.
- Ordering: entries leave strictly in acceptance order. Nothing is dropped or duplicated under any v_i/yumi_i pattern.
- Arithmetic, computed between S1 and S2:
  - mode 0: o = index*banks_p + bank, using an exact o_width_lp-bit product and no truncation. Maximum value is banks_p*2^width_p - 1.
  - mode 1: o = {bank, index}, i.e. bank*2^width_p + index.
  - Power-of-two banks_p in mode 0 reduces to o = {index, bank[lg_banks_lp-1:0]}.
- banks_p=1: o = index_i, bank_i is ignored, err_o is always 0. This equals the legacy identity mapping plus two cycles of latency.
- Range check, banks_p>1: err = (bank_i >= banks_p). When err=1, o is forced to 0 and err_o=1 travels with the entry.
- err_count_o increments on each cycle where v_o & yumi_i & err_o. It saturates at 255 and does not wrap. It is cleared only by reset.
- Outputs are stable while v_o=1 and yumi_i=0, and hold their last values when v_o=0.
- yumi_i asserted while v_o=0 is illegal; the assertion fires in simulation.

Test Plan:
- width_p=4, banks_p=3, mode_p=0; index 5, bank 2, yumi_i=1 -> v_o two cycles after accept, o=17 (6'b010001), err_o=0.
- width_p=4, banks_p=3, mode_p=1; index 5, bank 2 -> o=37. Sweep all index/bank pairs -> each o unique, max 47, no truncation.
- banks_p=3; bank 3 -> err_o=1, o=0, err_count_o=1 after consume. Send 300 bad entries -> err_count_o saturates at 255.
- Backpressure with defaults: v_i=1 continuous, yumi_i=0 -> exactly 2 entries accepted, ready_o=0 after. Release yumi_i -> outputs in order, back-to-back, one per cycle.
- Assert reset_i for 1 cycle with both stages full -> next cycle v_o=0, err_count_o=0. The stale entries never appear.
- banks_p=1, width_p=16; index 16'hBEEF, bank_i=1 -> o=16'hBEEF, err_o=0.

Source files
------------

// File: rtl/bsg_hash_bank_reverse_pipe.sv
// bsg_hash_bank_reverse_pipe
// Rebuilds a global address from a bank-local index and a bank id over two
// registered stages with valid/ready on the input and valid/yumi on the output.
// Supports low-order (index*banks+bank) and high-order ({bank,index})
// interleave for any bank count, and flags/counts out-of-range bank ids.

module bsg_hash_bank_reverse_pipe #(
  parameter int width_p = 16,
  parameter int banks_p = 4,
  parameter int mode_p  = 0,
  localparam int lg_banks_lp   = (banks_p > 1) ? $clog2(banks_p) : 0,
  localparam int bank_width_lp = (lg_banks_lp >= 1) ? lg_banks_lp : 1,
  localparam int o_width_lp    = width_p + lg_banks_lp
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [width_p-1:0]       index_i,
  input  logic [bank_width_lp-1:0] bank_i,
  output logic                     v_o,
  output logic [o_width_lp-1:0]    o,
  output logic                     err_o,
  input  logic                     yumi_i,
  output logic [7:0]               err_count_o
);

  // stage 1: captured index/bank plus range-check result
  logic                     r_v1;
  logic [width_p-1:0]       r_index1;
  logic [bank_width_lp-1:0] r_bank1;
  logic                     r_err1;

  // stage 2: computed address and error flag presented to the consumer
  logic                     r_v2;
  logic [o_width_lp-1:0]    r_o2;
  logic                     r_err2;
  logic [7:0]               r_err_cnt;

  logic                     w_s2_load;
  logic                     w_s1_adv;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_bank_err;
  logic                     w_consume_err;
  logic [o_width_lp-1:0]    w_index_ext;
  logic [o_width_lp-1:0]    w_bank_ext;
  logic [o_width_lp-1:0]    w_addr;

  // Handshake: S2 frees up when empty or being consumed; ready is held low in reset
  always_comb begin
    w_s2_load     = ~r_v2 | yumi_i;
    w_s1_adv      = r_v1 & w_s2_load;
    w_ready       = ~reset_i & (~r_v1 | w_s1_adv);
    w_accept      = v_i & w_ready;
    w_consume_err = r_v2 & yumi_i & r_err2;
  end

  assign ready_o     = w_ready;
  assign v_o         = r_v2;
  assign o           = r_o2;
  assign err_o       = r_err2;
  assign err_count_o = r_err_cnt;

  // Range check on the incoming bank id; a single bank never errors
  always_comb begin
    w_bank_err = 1'b0;
    if (banks_p > 1) begin
      w_bank_err = (32'(bank_i) >= 32'(banks_p));
    end else begin
      w_bank_err = 1'b0;
    end
  end

  // Address reconstruction from the S1 contents; errored entries produce zero
  always_comb begin
    w_index_ext = o_width_lp'(r_index1);
    w_bank_ext  = {o_width_lp{1'b0}};
    w_addr      = {o_width_lp{1'b0}};
    if (banks_p > 1) begin
      w_bank_ext = o_width_lp'(r_bank1);
    end else begin
      w_bank_ext = {o_width_lp{1'b0}};
    end
    if (r_err1) begin
      w_addr = {o_width_lp{1'b0}};
    end else if (mode_p == 0) begin
      // exact product: banks_p*2^width_p - 1 always fits in o_width_lp bits
      w_addr = (w_index_ext * o_width_lp'(banks_p)) + w_bank_ext;
    end else begin
      w_addr = (w_bank_ext << width_p) | w_index_ext;
    end
  end

  // Stage 1 register: load a new entry whenever the input handshake fires
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v1     <= 1'b0;
      r_index1 <= {width_p{1'b0}};
      r_bank1  <= {bank_width_lp{1'b0}};
      r_err1   <= 1'b0;
    end else if (w_ready) begin
      r_v1 <= v_i;
      if (w_accept) begin
        r_index1 <= index_i;
        r_bank1  <= bank_i;
        r_err1   <= w_bank_err;
      end
    end
  end

  // Stage 2 register: data only changes when a real entry moves in, so outputs hold otherwise
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v2   <= 1'b0;
      r_o2   <= {o_width_lp{1'b0}};
      r_err2 <= 1'b0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_o2   <= w_addr;
        r_err2 <= r_err1;
      end
    end
  end

  // Saturating count of errored entries taken by the consumer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err_cnt <= 8'd0;
    end else if (w_consume_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  bsg_hash_bank_reverse_pipe_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_o     (r_v2),
    .yumi_i  (yumi_i)
  );

endmodule

// Protocol checker: the consumer may only take an entry that is being offered
module bsg_hash_bank_reverse_pipe_chk (
  input logic clk_i,
  input logic reset_i,
  input logic v_o,
  input logic yumi_i
);

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_hash_bank_reverse_pipe.sv
// Directed bench for bsg_hash_bank_reverse_pipe. Four instances share one
// stimulus stream: (w4,b3,low), (w4,b3,high), (w16,b1) and the defaults.
module tb_bsg_hash_bank_reverse_pipe;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        consume;
  logic [15:0] index;
  logic [1:0]  bank;
  logic        yumi;

  logic       a_ready, a_vo, a_err; logic [5:0]  a_o; logic [7:0] a_cnt;
  logic       b_ready, b_vo, b_err; logic [5:0]  b_o; logic [7:0] b_cnt;
  logic       c_ready, c_vo, c_err; logic [15:0] c_o; logic [7:0] c_cnt;
  logic       d_ready, d_vo, d_err; logic [17:0] d_o; logic [7:0] d_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // all instances share identical handshake timing; yumi only when something is offered
  assign yumi = consume & d_vo;

  bsg_hash_bank_reverse_pipe #(.width_p(4), .banks_p(3), .mode_p(0)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(a_ready),
    .index_i(index[3:0]), .bank_i(bank), .v_o(a_vo), .o(a_o), .err_o(a_err),
    .yumi_i(yumi), .err_count_o(a_cnt));

  bsg_hash_bank_reverse_pipe #(.width_p(4), .banks_p(3), .mode_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(b_ready),
    .index_i(index[3:0]), .bank_i(bank), .v_o(b_vo), .o(b_o), .err_o(b_err),
    .yumi_i(yumi), .err_count_o(b_cnt));

  bsg_hash_bank_reverse_pipe #(.width_p(16), .banks_p(1), .mode_p(0)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(c_ready),
    .index_i(index), .bank_i(bank[0:0]), .v_o(c_vo), .o(c_o), .err_o(c_err),
    .yumi_i(yumi), .err_count_o(c_cnt));

  bsg_hash_bank_reverse_pipe dut_d (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(d_ready),
    .index_i(index), .bank_i(bank), .v_o(d_vo), .o(d_o), .err_o(d_err),
    .yumi_i(yumi), .err_count_o(d_cnt));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; consume = 1'b0; index = 16'd0; bank = 2'd0;

    // reset state
    tick; tick;
    chk("rst_vo",     32'(d_vo), 32'd0);
    chk("rst_ready",  32'(d_ready), 32'd0);
    chk("rst_o",      32'(d_o), 32'd0);
    chk("rst_err",    32'(d_err), 32'd0);
    chk("rst_cnt",    32'(d_cnt), 32'd0);
    chk("rst_a_o",    32'(a_o), 32'd0);
    reset_i = 1'b0;
    #1;
    chk("post_rst_ready_a", 32'(a_ready), 32'd1);
    chk("post_rst_ready_b", 32'(b_ready), 32'd1);
    chk("post_rst_ready_c", 32'(c_ready), 32'd1);
    chk("post_rst_ready_d", 32'(d_ready), 32'd1);

    // single entry index 5 bank 2, latency two cycles
    consume = 1'b1; v_i = 1'b1; index = 16'd5; bank = 2'd2;
    tick;
    chk("lat1_vo", 32'(a_vo), 32'd0);
    v_i = 1'b0;
    tick;
    chk("lat2_vo_a", 32'(a_vo), 32'd1);
    chk("lat2_vo_b", 32'(b_vo), 32'd1);
    chk("lat2_vo_c", 32'(c_vo), 32'd1);
    chk("low_o",     32'(a_o), 32'd17);
    chk("low_err",   32'(a_err), 32'd0);
    chk("high_o",    32'(b_o), 32'd37);
    chk("one_bank_o", 32'(c_o), 32'd5);
    chk("dflt_o",    32'(d_o), 32'd22);
    tick;
    chk("drain_vo",  32'(a_vo), 32'd0);
    chk("hold_o",    32'(a_o), 32'd17);

    // sweep every (index, bank) pair back-to-back: high-order gives 0..47 in order
    for (int k = 0; k <= 48; k++) begin
      if (k < 48) begin
        v_i = 1'b1; index = 16'(k % 16); bank = 2'(k / 16);
      end else begin
        v_i = 1'b0;
      end
      tick;
      if (k >= 1) begin
        chk("sweep_vo",   32'(b_vo), 32'd1);
        chk("sweep_high", 32'(b_o), 32'(k - 1));
        chk("sweep_low",  32'(a_o), 32'((((k - 1) % 16) * 3) + ((k - 1) / 16)));
      end
    end
    tick;
    chk("sweep_end_vo", 32'(b_vo), 32'd0);
    chk("sweep_max",    32'(b_o), 32'd47);

    // out-of-range bank
    v_i = 1'b1; index = 16'd5; bank = 2'd3;
    tick;
    v_i = 1'b0;
    tick;
    chk("bad_err_a", 32'(a_err), 32'd1);
    chk("bad_o_a",   32'(a_o), 32'd0);
    chk("bad_err_b", 32'(b_err), 32'd1);
    chk("bad_cnt_pre", 32'(a_cnt), 32'd0);
    chk("ok_bank3_d", 32'(d_o), 32'd23);
    chk("ok_err_d",  32'(d_err), 32'd0);
    chk("c_err",     32'(c_err), 32'd0);
    chk("c_o_bank_ignored", 32'(c_o), 32'd5);
    tick;
    chk("bad_cnt_a", 32'(a_cnt), 32'd1);
    chk("bad_cnt_b", 32'(b_cnt), 32'd1);
    chk("bad_cnt_d", 32'(d_cnt), 32'd0);

    // 300 more bad entries streamed: counter saturates at 255
    for (int k = 0; k < 300; k++) begin
      v_i = 1'b1; index = 16'(k); bank = 2'd3;
      tick;
      if (k == 100) chk("sat_100", 32'(a_cnt), 32'd100);
      if (k == 254) chk("sat_254", 32'(a_cnt), 32'd254);
      if (k == 255) chk("sat_255", 32'(a_cnt), 32'd255);
      if (k == 256) chk("sat_hold", 32'(a_cnt), 32'd255);
    end
    v_i = 1'b0;
    tick; tick;
    chk("sat_end_vo", 32'(a_vo), 32'd0);
    chk("sat_end_a",  32'(a_cnt), 32'd255);
    chk("sat_end_b",  32'(b_cnt), 32'd255);
    chk("sat_end_c",  32'(c_cnt), 32'd0);

    // backpressure: only two entries fit
    consume = 1'b0; v_i = 1'b1; index = 16'd100; bank = 2'd1;
    tick;
    index = 16'd101;
    tick;
    chk("bp_ready", 32'(d_ready), 32'd0);
    chk("bp_vo",    32'(d_vo), 32'd1);
    chk("bp_o",     32'(d_o), 32'd401);
    index = 16'd102;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp_hold_ready", 32'(d_ready), 32'd0);
      chk("bp_hold_o",     32'(d_o), 32'd401);
    end
    consume = 1'b1;
    #1;
    chk("bp_release_ready", 32'(d_ready), 32'd1);
    tick;
    chk("bp_out1_vo", 32'(d_vo), 32'd1);
    chk("bp_out1",    32'(d_o), 32'd405);
    v_i = 1'b0;
    tick;
    chk("bp_out2_vo", 32'(d_vo), 32'd1);
    chk("bp_out2",    32'(d_o), 32'd409);
    tick;
    chk("bp_empty",   32'(d_vo), 32'd0);
    chk("bp_hold_last", 32'(d_o), 32'd409);

    // reset with both stages full discards everything
    consume = 1'b0; v_i = 1'b1; index = 16'd200; bank = 2'd3;
    tick;
    index = 16'd201;
    tick;
    chk("full_vo",  32'(d_vo), 32'd1);
    chk("full_rdy", 32'(d_ready), 32'd0);
    chk("full_err_a", 32'(a_err), 32'd1);
    reset_i = 1'b1; v_i = 1'b0;
    tick;
    chk("midrst_vo",  32'(d_vo), 32'd0);
    chk("midrst_cnt", 32'(a_cnt), 32'd0);
    chk("midrst_o",   32'(d_o), 32'd0);
    reset_i = 1'b0; consume = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stale_vo",  32'(d_vo), 32'd0);
      chk("stale_cnt", 32'(a_cnt), 32'd0);
    end

    // single bank identity mapping, bank input ignored
    v_i = 1'b1; index = 16'hBEEF; bank = 2'd1;
    tick;
    v_i = 1'b0;
    tick;
    chk("id_vo",  32'(c_vo), 32'd1);
    chk("id_o",   32'(c_o), 32'hBEEF);
    chk("id_err", 32'(c_err), 32'd0);
    chk("beef_d", 32'(d_o), 32'h2FBBD);
    chk("beef_a", 32'(a_o), 32'd46);
    chk("beef_b", 32'(b_o), 32'd31);
    chk("beef_a_err", 32'(a_err), 32'd0);
    tick;
    chk("final_vo", 32'(d_vo), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
